// File: rtl/rf_lane_packer_if.sv
// Bundles the particle word stream (valid/ready/data/last) and the port-A write bus
// of the particle register file.
//   slave  : packer side. It consumes the stream and drives the register-file bus.
//   master : environment side. It drives the stream and observes the register-file bus.
// Signals:
//   in_valid/in_data/in_last  word stream into the packer
//   in_ready                  packer accepts in_data this cycle
//   rf_a/rf_dia               port A address / write data
//   rf_wean/rf_csa            write enable (active-low) / chip select
//   rf_muxa                   per-lane write mask
interface rf_lane_packer_if #(
    parameter int LANE_W = 16,
    parameter int LANES  = 4,
    parameter int AW     = 4
);
    logic                    in_valid;
    logic [LANE_W-1:0]       in_data;
    logic                    in_last;
    logic                    in_ready;
    logic [AW-1:0]           rf_a;
    logic [LANE_W*LANES-1:0] rf_dia;
    logic                    rf_wean;
    logic                    rf_csa;
    logic [LANES-1:0]        rf_muxa;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, rf_a, rf_dia, rf_wean, rf_csa, rf_muxa
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, rf_a, rf_dia, rf_wean, rf_csa, rf_muxa
    );
endinterface

// File: rtl/rf_lane_packer.sv
// Packs a stream of LANE_W-bit particle words, LANES per line with lane 0 first.
// Each packed line is written into the DEPTH-entry register file through port A
// as a single masked write. A short final line writes only the lanes that were filled.
// If the stream runs past the last entry, the rest of the stream is drained and
// overflow is flagged.
// Ports:
//   clk, reset      clock (rising edge); asynchronous active-high reset
//   start_i         pulse, honoured in IDLE only; begins a load at base_addr_i
//   base_addr_i     first register-file entry written
//   bus             stream in / port-A write bus (rf_lane_packer_if.slave)
//   busy_o          high in every state except IDLE and DONE
//   done_o          one-cycle pulse at the end of a load
//   overflow_o      sticky; the load ran past entry DEPTH-1 (cleared by next start)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start_i
// S_FILL  | accepting words into the line buffer
// S_WRITE | one-cycle masked write of the line buffer to port A
// S_DRAIN | accepting and discarding words until in_last
// S_DONE  | done_o pulse, then return to IDLE
module rf_lane_packer #(
    parameter int LANE_W = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 10,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [AW-1:0]     base_addr_i,
    rf_lane_packer_if.slave   bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);
    localparam int LINE_W = LANE_W * LANES;
    localparam int LI_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LI_W-1:0] LAST_LANE = LI_W'(LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LI_W-1:0]   lane_q, lane_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              last_q, last_d;
    logic              overflow_q, overflow_d;

    // Output registers. They are loaded from next-state values, so a line that
    // completes at edge n is already on port A during the cycle that follows.
    logic              in_ready_q, in_ready_d;
    logic [AW-1:0]     rf_a_q, rf_a_d;
    logic [LINE_W-1:0] rf_dia_q, rf_dia_d;
    logic              rf_wean_q, rf_wean_d;
    logic              rf_csa_q, rf_csa_d;
    logic [LANES-1:0]  rf_muxa_q, rf_muxa_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept;
    logic wr_next;

    // in_ready_q is high exactly in FILL and DRAIN.
    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        line_d     = line_q;
        mask_d     = mask_q;
        last_d     = last_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d     = base_addr_i;
                    lane_d     = '0;
                    line_d     = '0;
                    mask_d     = '0;
                    last_d     = 1'b0;
                    overflow_d = 1'b0;
                    if (base_addr_i > LAST_ADDR) begin
                        overflow_d = 1'b1;
                        state_d    = S_DRAIN;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (lane_q == LI_W'(i)) begin
                            line_d[i*LANE_W +: LANE_W] = bus.in_data;
                            mask_d[i]                  = 1'b1;
                        end
                    end
                    lane_d = lane_q + LI_W'(1);
                    if ((lane_q == LAST_LANE) || bus.in_last) begin
                        last_d  = bus.in_last;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                line_d = '0;
                mask_d = '0;
                lane_d = '0;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (addr_q == LAST_ADDR) begin
                    overflow_d = 1'b1;
                    state_d    = S_DRAIN;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = S_FILL;
                end
            end
            S_DRAIN: begin
                if (accept && bus.in_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_next    = (state_d == S_WRITE);
        in_ready_d = (state_d == S_FILL) || (state_d == S_DRAIN);
        rf_a_d     = wr_next ? addr_d : '0;
        rf_dia_d   = wr_next ? line_d : '0;
        rf_muxa_d  = wr_next ? mask_d : '0;
        rf_wean_d  = !wr_next;
        rf_csa_d   = wr_next;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            lane_q     <= '0;
            line_q     <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            in_ready_q <= 1'b0;
            rf_a_q     <= '0;
            rf_dia_q   <= '0;
            rf_wean_q  <= 1'b1;
            rf_csa_q   <= 1'b0;
            rf_muxa_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            line_q     <= line_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            in_ready_q <= in_ready_d;
            rf_a_q     <= rf_a_d;
            rf_dia_q   <= rf_dia_d;
            rf_wean_q  <= rf_wean_d;
            rf_csa_q   <= rf_csa_d;
            rf_muxa_q  <= rf_muxa_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.rf_a     = rf_a_q;
    assign bus.rf_dia   = rf_dia_q;
    assign bus.rf_wean  = rf_wean_q;
    assign bus.rf_csa   = rf_csa_q;
    assign bus.rf_muxa  = rf_muxa_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_rf_lane_packer.sv
// Directed bench for rf_lane_packer: drives word streams and collects every
// port-A write strobe, then compares it against hand-computed lines.
module tb_rf_lane_packer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic [3:0] base_addr_i;
    logic       busy_o, done_o, overflow_o;

    rf_lane_packer_if bus ();

    rf_lane_packer dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [63:0] d;
        logic [3:0]  m;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc      = 0;
    int  viol     = 0;
    int  done_cnt = 0;
    int  n_vec    = 0;
    int  n_err    = 0;
    int  acc_cyc  = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: captures write strobes and checks bus invariants.
    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.rf_wean) wq.push_back('{a: bus.rf_a, d: bus.rf_dia, m: bus.rf_muxa, cyc: cyc});
            if (!bus.rf_wean && (bus.in_ready || !bus.rf_csa)) viol++;
            if (bus.rf_wean && (bus.rf_csa || bus.rf_dia != 64'd0 || bus.rf_muxa != 4'd0)) viol++;
            if (busy_o && bus.rf_wean && !bus.in_ready) viol++;
            if (bus.rf_a > 4'd9) viol++;
            if (done_o) done_cnt++;
            if (done_o && done_prev) viol++;
            done_prev = done_o;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [3:0] base);
        @(posedge clk); #1;
        start_i     = 1'b1;
        base_addr_i = base;
        @(posedge clk); #1;
        start_i     = 1'b0;
    endtask

    // Present one word and hold it until accepted; acc_cyc marks the accepting edge.
    task automatic send(input logic [15:0] d, input logic last);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {63'd0, done_o}, 64'd1);
        chk({tag, "_busy_in_done"}, {63'd0, busy_o}, 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, {63'd0, done_o}, 64'd0);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    task automatic check_wr(input int idx, input logic [3:0] a, input logic [63:0] d, input logic [3:0] m);
        if (idx < wq.size()) begin
            chk($sformatf("wr%0d_addr", idx), {60'd0, wq[idx].a}, {60'd0, a});
            chk($sformatf("wr%0d_data", idx), wq[idx].d, d);
            chk($sformatf("wr%0d_mask", idx), {60'd0, wq[idx].m}, {60'd0, m});
        end else begin
            chk($sformatf("wr%0d_present", idx), wq.size(), idx + 1);
        end
    endtask

    task automatic new_test();
        wq.delete();
        done_cnt = 0;
    endtask

    initial begin
        int sz;
        reset        = 1'b1;
        start_i      = 1'b0;
        base_addr_i  = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'd0;
        bus.in_last  = 1'b0;
        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_rf_a", {60'd0, bus.rf_a}, 64'd0);
        chk("rst_rf_dia", bus.rf_dia, 64'd0);
        chk("rst_rf_wean", {63'd0, bus.rf_wean}, 64'd1);
        chk("rst_rf_csa", {63'd0, bus.rf_csa}, 64'd0);
        chk("rst_rf_muxa", {60'd0, bus.rf_muxa}, 64'd0);
        chk("rst_flags", {61'd0, busy_o, done_o, overflow_o}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Two full lines from entry 2.
        new_test();
        start_load(4'd2);
        for (int i = 1; i <= 8; i++) send(16'(i), i == 8);
        wait_done("t1");
        chk("t1_count", wq.size(), 2);
        check_wr(0, 4'd2, 64'h0004_0003_0002_0001, 4'b1111);
        check_wr(1, 4'd3, 64'h0008_0007_0006_0005, 4'b1111);
        if (wq.size() == 2) chk("t1_throughput", wq[1].cyc - wq[0].cyc, 5);
        chk("t1_overflow", {63'd0, overflow_o}, 64'd0);

        // Full line then a one-word partial line.
        new_test();
        start_load(4'd0);
        for (int i = 0; i < 5; i++) send(16'hA0 + 16'(i), i == 4);
        wait_done("t2");
        chk("t2_count", wq.size(), 2);
        check_wr(0, 4'd0, 64'h00A3_00A2_00A1_00A0, 4'b1111);
        check_wr(1, 4'd1, 64'h0000_0000_0000_00A4, 4'b0001);

        // Runs past the last entry: one write at 9, the rest drained.
        new_test();
        start_load(4'd9);
        for (int i = 0; i < 6; i++) send(16'h10 + 16'(i), i == 5);
        wait_done("t3");
        chk("t3_count", wq.size(), 1);
        check_wr(0, 4'd9, 64'h0013_0012_0011_0010, 4'b1111);
        chk("t3_overflow", {63'd0, overflow_o}, 64'd1);

        // Base beyond the file: straight to drain, no writes.
        new_test();
        start_load(4'd12);
        chk("t7_overflow_at_start", {63'd0, overflow_o}, 64'd1);
        send(16'h55, 1'b0);
        send(16'h56, 1'b1);
        wait_done("t7");
        chk("t7_count", wq.size(), 0);

        // in_valid toggling; overflow cleared by the new start.
        new_test();
        start_load(4'd4);
        chk("t4_overflow_cleared", {63'd0, overflow_o}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            send(16'hB0 + 16'(i), i == 3);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        sz = acc_cyc;
        wait_done("t4");
        chk("t4_count", wq.size(), 1);
        check_wr(0, 4'd4, 64'h00B3_00B2_00B1_00B0, 4'b1111);
        if (wq.size() == 1) chk("t4_latency", wq[0].cyc, sz);

        // Reset after two words of a line.
        new_test();
        start_load(4'd0);
        send(16'hE0, 1'b0);
        send(16'hE1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_wean", {63'd0, bus.rf_wean}, 64'd1);
        chk("t5_rst_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("t5_rst_busy", {63'd0, busy_o}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_no_write", wq.size(), 0);
        start_load(4'd0);
        for (int i = 0; i < 4; i++) send(16'hC0 + 16'(i), i == 3);
        wait_done("t5");
        chk("t5_count", wq.size(), 1);
        check_wr(0, 4'd0, 64'h00C3_00C2_00C1_00C0, 4'b1111);

        // start while busy is ignored.
        new_test();
        start_load(4'd3);
        send(16'hD0, 1'b0);
        send(16'hD1, 1'b0);
        start_i     = 1'b1;
        base_addr_i = 4'd7;
        @(posedge clk); #1;
        start_i     = 1'b0;
        send(16'hD2, 1'b0);
        send(16'hD3, 1'b1);
        wait_done("t6");
        chk("t6_count", wq.size(), 1);
        check_wr(0, 4'd3, 64'h00D3_00D2_00D1_00D0, 4'b1111);

        // Reset in the middle of a write strobe drops it at once.
        new_test();
        start_load(4'd5);
        for (int i = 0; i < 4; i++) send(16'hF0 + 16'(i), 1'b0);
        chk("t8_strobe_on", {63'd0, bus.rf_wean}, 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("t8_strobe_dropped", {63'd0, bus.rf_wean}, 64'd1);
        chk("t8_csa_dropped", {63'd0, bus.rf_csa}, 64'd0);
        chk("t8_dia_cleared", bus.rf_dia, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("bus_invariants", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
